// File: rtl/gray_frame_packer.sv
// Packs the cropped 8-bit grayscale pixel stream into 256-bit DMEM words and writes
// one full frame per CPU request, then raises oDONE until the request is withdrawn.
module gray_frame_packer #(
  parameter int         PIX_COUNT = 784,
  parameter logic [6:0] BASE_ADDR = 7'd0
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iENABLE,
  input  logic         iFVAL,
  input  logic         iDVAL,
  input  logic [11:0]  iDATA,
  output logic         oDONE,
  output logic         oWREN,
  output logic [6:0]   oWRADDR,
  output logic [255:0] oWRDATA,
  output logic         oBUSY
);

  localparam int            CW       = $clog2(PIX_COUNT);
  localparam logic [CW-1:0] LAST_PIX = CW'(PIX_COUNT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, CAPTURE, FLUSH, DONE} state_t;

  state_t          state_r;
  logic            fval_r;
  logic            fval_d_r;
  logic [CW-1:0]   pix_cnt_r;
  logic [6:0]      word_addr_r;
  logic [255:0]    acc_r;
  logic            fval_rise_s;
  logic [4:0]      lane_s;
  logic [255:0]    acc_next_s;
  logic            data_unused_s;

  assign fval_rise_s   = fval_r & ~fval_d_r;
  assign lane_s        = pix_cnt_r[4:0];
  assign data_unused_s = ^iDATA[3:0];

  // Accumulator with the incoming pixel dropped into its lane
  always_comb begin
    acc_next_s = acc_r;
    acc_next_s[{lane_s, 3'b000} +: 8] = iDATA[11:4];
  end

  // Two-stage iFVAL history so only a clean 0->1 transition opens a capture
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fval_r   <= 1'b0;
      fval_d_r <= 1'b0;
    end else begin
      fval_r   <= iFVAL;
      fval_d_r <= fval_r;
    end
  end

  // Capture FSM with registered DMEM write port and status outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r     <= IDLE;
      pix_cnt_r   <= '0;
      word_addr_r <= BASE_ADDR;
      acc_r       <= 256'd0;
      oDONE       <= 1'b0;
      oWREN       <= 1'b0;
      oWRADDR     <= BASE_ADDR;
      oWRDATA     <= 256'd0;
      oBUSY       <= 1'b0;
    end else begin
      oWREN <= 1'b0;
      case (state_r)
        IDLE: begin
          pix_cnt_r   <= '0;
          acc_r       <= 256'd0;
          word_addr_r <= BASE_ADDR;
          oDONE       <= 1'b0;
          if (iENABLE) begin
            state_r <= WAIT_FRAME;
            oBUSY   <= 1'b1;
          end else begin
            oBUSY   <= 1'b0;
          end
        end
        WAIT_FRAME: begin
          if (!iENABLE) begin
            state_r <= IDLE;
            oBUSY   <= 1'b0;
          end else if (fval_rise_s) begin
            state_r <= CAPTURE;
          end else begin
            state_r <= WAIT_FRAME;
          end
        end
        CAPTURE: begin
          if (!iENABLE) begin
            state_r <= IDLE;
            oBUSY   <= 1'b0;
          end else if (!iFVAL) begin
            // Short frame: discard it and let the next frame overwrite from the base
            state_r     <= WAIT_FRAME;
            pix_cnt_r   <= '0;
            acc_r       <= 256'd0;
            word_addr_r <= BASE_ADDR;
          end else if (iDVAL) begin
            pix_cnt_r <= pix_cnt_r + CW'(1);
            if (lane_s == 5'd31) begin
              oWREN       <= 1'b1;
              oWRADDR     <= word_addr_r;
              oWRDATA     <= acc_next_s;
              word_addr_r <= word_addr_r + 7'd1;
              acc_r       <= 256'd0;
            end else begin
              acc_r       <= acc_next_s;
            end
            if (pix_cnt_r == LAST_PIX) begin
              if (lane_s == 5'd31) begin
                state_r <= DONE;
                oBUSY   <= 1'b0;
              end else begin
                state_r <= FLUSH;
              end
            end else begin
              state_r <= CAPTURE;
            end
          end else begin
            state_r <= CAPTURE;
          end
        end
        FLUSH: begin
          oBUSY <= 1'b0;
          if (!iENABLE) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
            oWREN   <= 1'b1;
            oWRADDR <= word_addr_r;
            oWRDATA <= acc_r;
          end
        end
        DONE: begin
          if (!iENABLE) begin
            state_r <= IDLE;
            oDONE   <= 1'b0;
          end else begin
            oDONE   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          oDONE   <= 1'b0;
          oBUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gray_frame_packer.md
# gray_frame_packer

Packs the cropped 28x28 grayscale pixel stream leaving the crop-down stage into 256-bit data-memory words and writes one complete frame to DMEM per CPU request. It sits between the crop-down stage and the DMEM write port inside the image-processing state machine. It drives the `dmem_wren`/`dmem_wraddr`/`dmem_wrdata` and `ccd_done` signals seen by the CPU.

## Interface
- `PIX_COUNT`, 784: pixels per frame (28x28).
- `BASE_ADDR`, 7'd0: DMEM word address of the first frame word. Constraint: `BASE_ADDR + ceil(PIX_COUNT/32) - 1 <= 127`; a violating value is a configuration error.
- `iCLK` input 1: pixel clock; all logic on its rising edge.
- `iRST` input 1: reset, asynchronous and active-high.
- `iENABLE` input 1: CPU capture request; level-sensitive.
- `iFVAL` input 1: frame valid from the capture pipeline.
- `iDVAL` input 1: pixel strobe; `iDATA` is valid in this cycle.
- `iDATA` input 12: grayscale pixel; bits [11:4] are stored.
- `oDONE` input→output 1: frame fully written; drives `ccd_done`.
- `oWREN` output 1: DMEM write strobe, single cycle per word.
- `oWRADDR` output 7: DMEM word address.
- `oWRDATA` output 256: DMEM word data.
- `oBUSY` output 1: high in WAIT_FRAME, CAPTURE and FLUSH.

## Operation
- **Packing**
  - Each accepted pixel is stored as 8 bits, `iDATA[11:4]`.
  - Pixel k of a word (0..31, in arrival order) goes to bits [8k+7:8k], so the first pixel is in the LSB.
- **Frame layout**
  - 784 pixels fill 24 full words plus one half word.
  - Word 24 holds pixels 768..783 in bits [127:0]; bits [255:128] are zero.
- **States:** IDLE, WAIT_FRAME, CAPTURE, FLUSH, DONE.
  - IDLE: `iENABLE`=1 → WAIT_FRAME. The pixel counter, word index and accumulator are cleared.
  - WAIT_FRAME: move to CAPTURE on a registered rising edge of `iFVAL` (previous 0, current 1). A frame already in progress is never captured.
  - CAPTURE: each `iDVAL` cycle accepts one pixel.
    - When word lane 31 fills, the word is copied to the output register, `oWREN` pulses, the address increments, and the accumulator clears.
    - A pixel arriving in the cycle after a word completes goes into the fresh accumulator with no stall.
    - After pixel 784 is accepted → FLUSH.
  - FLUSH: write the partial word 24, zero-padded, then → DONE.
  - DONE: `oDONE`=1. Further `iDVAL`/`iFVAL` activity is ignored. `iENABLE`=0 → IDLE with `oDONE`=0.
- **Boundary cases**
  - `iFVAL` falls in CAPTURE before 784 pixels: discard the partial word, return to WAIT_FRAME, and reset the address to `BASE_ADDR`. The next frame overwrites the words already written. No `oDONE`.
  - `iENABLE` drops in WAIT_FRAME, CAPTURE or FLUSH: go to IDLE next cycle. No further `oWREN`; a write already registered in the current cycle still completes.
  - `iDVAL` in the same cycle as an `iFVAL` fall in CAPTURE: the pixel is dropped and the abort takes priority.
  - Address never wraps: the last address is `BASE_ADDR+24`.

## Timing
- Reset values: state IDLE; `oDONE`, `oWREN`, `oBUSY` = 0; `oWRADDR` = `BASE_ADDR`; `oWRDATA` = 0; counters and accumulator = 0.
- `oWREN` is registered and rises the cycle after the `iDVAL` cycle that accepted pixel 32n+31. `oWRADDR`/`oWRDATA` are valid in that same cycle and held until the next write.
- The final write (word 24) occurs the cycle after FLUSH is entered, i.e. 2 cycles after pixel 783 is accepted.
- `oDONE` rises the cycle after the final `oWREN`. It stays high until the cycle after `iENABLE` is seen low.
- Enable to WAIT_FRAME: 1 cycle. `iFVAL` rise to CAPTURE: 2 cycles. A pixel on the first CAPTURE cycle is accepted.
- Exactly 25 `oWREN` pulses per completed frame.

## Test plan
- **Full frame, ramp pixels:** `iDATA` = {k[7:0],4'h0} for k=0..783, continuous `iDVAL` → 25 writes at addresses 0..24. Word 0 = bytes 0x00..0x1F with LSB first. Word 24 bits [127:0] = bytes 0x00..0x0F (768 mod 256), upper bits zero. `oDONE` rises 1 cycle after the last write.
- **Gapped `iDVAL`:** random 50% duty on `iDVAL` → same 25 words and addresses as the continuous case, with no dropped or duplicated pixels.
- **Mid-frame arm:** `iENABLE` rises while `iFVAL`=1 → no writes until the next `iFVAL` rise. The captured data is the next frame's.
- **Early frame end:** `iFVAL` falls after 100 pixels → 3 writes (addresses 0..2), no `oDONE`. The next full frame rewrites addresses 0..24 and `oDONE` asserts.
- **Abort and reset:** `iENABLE` drops after 500 pixels → no writes after the drop cycle and `oDONE`=0. Separately, `iRST` pulsed mid-CAPTURE → all outputs return to their reset values immediately (asynchronous).
- **Handshake release:** in DONE, hold `iENABLE`=1 for 10 cycles → `oDONE` stays 1. Drop `iENABLE` → `oDONE`=0 next cycle. Re-raise `iENABLE` → a new capture starts at `BASE_ADDR`.
